vga_pattern_sched: RTL and testbench
====================================

VGA_PATTERN_SCHED -- requirements
Module: vga_pattern_sched

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter BAR_W, default 80, colour-bar width in pixels.
REQ-004 Parameter CHK_SH, default 5, checker square edge = 2^CHK_SH pixels.
REQ-005 clk  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 HPixel  in  16  current pixel column, from the VGA timing block.
REQ-008 VPixel  in  16  current pixel line, from the VGA timing block.
REQ-009 cfg_valid  in  1  config request valid.
REQ-010 cfg_ready  out  1  config slot free.
REQ-011 cfg_auto  in  1  1 = auto-cycle patterns; 0 = fixed pattern.
REQ-012 cfg_pat  in  2  fixed pattern, or start pattern in auto mode.
REQ-013 cfg_hold  in  8  frames per pattern in auto mode.
REQ-014 cfg_en  in  1  0 = blank output (IDLE).
REQ-015 inR, inG, inB  out  8 each  pixel colour to the VGA block.
REQ-016 pat_id  out  2  pattern currently displayed.
REQ-017 frame_start  out  1  one-cycle pulse on frame boundary.

Function
REQ-018 frame_start SHALL pulse for one cycle on the first cycle HPixel==0 and VPixel==0, after a cycle where that was false; it is not repeated while the condition holds.
REQ-019 Config handshake: a transfer occurs when cfg_valid and cfg_ready are both high at a rising edge; the fields are captured into a pending register.
REQ-020 cfg_ready SHALL go low the cycle after a transfer and return high the cycle after the pending config is applied.
REQ-021 Pending config SHALL be applied only on a frame_start cycle, never mid-frame.
REQ-022 If a transfer and frame_start coincide, the new config SHALL apply at the next frame_start.
REQ-023 FSM states: IDLE, FIXED, AUTO; all transitions occur only at config apply.
REQ-024 The next state is: IDLE if cfg_en==0; else AUTO if cfg_auto==1; else FIXED.
REQ-025 On apply: pat_id <= cfg_pat and hold_cnt <= 0.
REQ-026 In AUTO, hold_cnt SHALL increment on each frame_start.
REQ-027 In AUTO, when hold_cnt == max(cfg_hold,1)-1 at frame_start, pat_id SHALL increment (3 wraps to 0) and hold_cnt SHALL clear.
REQ-028 cfg_hold==0 SHALL behave as 1.
REQ-029 Patterns for visible pixels (HPixel<H_ACTIVE and VPixel<V_ACTIVE):
- 0: white, 255/255/255.
- 1: 8 bars, index = HPixel/BAR_W clamped to 7; bar i gives R=255*i[2], G=255*i[1], B=255*i[0].
- 2: checker; white when HPixel[CHK_SH]^VPixel[CHK_SH]==1, else black.
- 3: gradient; R=HPixel[9:2], G=VPixel[8:1], B=HPixel[9:2]^VPixel[8:1].
REQ-030 Non-visible pixels, and all pixels in IDLE, SHALL output 0/0/0.
REQ-031 inR/inG/inB SHALL be registered, with latency exactly 1 clock from HPixel/VPixel.
REQ-032 Bar division SHALL use a compare chain, not a divider.

Reset
REQ-033 On rst: state=IDLE, pat_id=0, hold_cnt=0, pending empty, cfg_ready=1, inR/inG/inB=0, frame_start=0.
REQ-034 rst asserted mid-frame or with a config pending SHALL discard the pending config.
REQ-035 After rst deasserts, the first frame_start requires a fresh HPixel==0/VPixel==0 edge.

Structure
REQ-036 A shared package vga_pkg SHALL hold the state encoding, pattern codes (PAT_WHITE, PAT_BARS, PAT_CHECK, PAT_GRAD) and the default H_ACTIVE/V_ACTIVE values.
REQ-037 Colour generation SHALL be one sub-module, vga_pattern_gen, containing the combinational pattern logic; the output register stays in the top level.

Verification
REQ-038 Reset, then apply cfg_en=1, cfg_auto=0, cfg_pat=1 -> from the next frame, pixel (85,10) outputs 0/0/255 one cycle later, and pixel (700,10) outputs 0/0/0.
REQ-039 AUTO, cfg_pat=2, cfg_hold=3 -> pat_id sequence per frame 2,2,2,3,3,3,0,...
REQ-040 cfg_hold=0 in AUTO -> pat_id advances every frame_start.
REQ-041 Transfer mid-frame -> cfg_ready stays low, output is unchanged until the next frame_start, and cfg_ready rises the cycle after it.
REQ-042 Transfer in the same cycle as frame_start -> applied one frame later.
REQ-043 rst pulse with a config pending -> outputs 0, cfg_ready=1, and the pending config is never applied.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA test-pattern scheduler.
// Holds state encoding, pattern codes and default raster size.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_AUTO  = 2'd2;

  localparam logic [1:0] PAT_WHITE = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  typedef struct packed {
    logic       en;
    logic       autom;
    logic [1:0] pat;
    logic [7:0] hold;
  } cfg_t;

  function automatic logic [1:0] cfg_state(input cfg_t c);
    if (!c.en)
      return ST_IDLE;
    else if (c.autom)
      return ST_AUTO;
    else
      return ST_FIXED;
  endfunction

  // A hold of zero frames is treated as one frame.
  function automatic logic [7:0] hold_last(input logic [7:0] h);
    return (h == 8'd0) ? 8'd0 : h - 8'd1;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational colour generator for the four test patterns.
// Blanks outside the visible area or when disabled.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BAR_W    = 80,
  parameter int CHK_SH   = 5
) (
  input  logic [15:0] hpix,
  input  logic [15:0] vpix,
  input  logic [1:0]  pat,
  input  logic        en,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  logic       vis;
  logic [2:0] bar;
  logic       chk;
  logic [7:0] gr_r;
  logic [7:0] gr_g;

  assign vis = (hpix < 16'(H_ACTIVE))
            && (vpix < 16'(V_ACTIVE));

  // Compare chain saturates at bar 7.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (hpix >= 16'(i * BAR_W))
        bar = 3'(i);
  end

  assign chk  = hpix[CHK_SH] ^ vpix[CHK_SH];
  assign gr_r = hpix[9:2];
  assign gr_g = vpix[8:1];

  always_comb begin
    r = 8'd0;
    g = 8'd0;
    b = 8'd0;
    if (en && vis) begin
      case (pat)
        PAT_WHITE: begin
          r = 8'hff;
          g = 8'hff;
          b = 8'hff;
        end
        PAT_BARS: begin
          r = {8{bar[2]}};
          g = {8{bar[1]}};
          b = {8{bar[0]}};
        end
        PAT_CHECK: begin
          r = {8{chk}};
          g = {8{chk}};
          b = {8{chk}};
        end
        default: begin
          r = gr_r;
          g = gr_g;
          b = gr_r ^ gr_g;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_pattern_sched.sv
// Test-pattern scheduler: frame-synchronous config apply,
// fixed/auto pattern sequencing and registered colour output.
module vga_pattern_sched
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BAR_W    = 80,
  parameter int CHK_SH   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] HPixel,
  input  logic [15:0] VPixel,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_auto,
  input  logic [1:0]  cfg_pat,
  input  logic [7:0]  cfg_hold,
  input  logic        cfg_en,
  output logic [7:0]  inR,
  output logic [7:0]  inG,
  output logic [7:0]  inB,
  output logic [1:0]  pat_id,
  output logic        frame_start
);

  logic       at_org;
  logic       org_q;
  logic       xfer;
  logic       apply;
  logic       pend_vld;
  cfg_t       pend_q;
  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [7:0] hold_lim;
  logic [7:0] gen_r;
  logic [7:0] gen_g;
  logic [7:0] gen_b;

  assign at_org      = (HPixel == 16'd0) && (VPixel == 16'd0);
  assign frame_start = at_org && !org_q;
  assign cfg_ready   = !pend_vld;
  assign xfer        = cfg_valid && cfg_ready;
  assign apply       = frame_start && pend_vld;

  // Reset to "at origin" so a fresh origin edge is needed after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      org_q <= 1'b1;
    else
      org_q <= at_org;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_q   <= '0;
    end else if (xfer) begin
      pend_vld <= 1'b1;
      pend_q   <= '{en: cfg_en, autom: cfg_auto,
                    pat: cfg_pat, hold: cfg_hold};
    end else if (apply) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pat_id   <= PAT_WHITE;
      hold_cnt <= 8'd0;
      hold_lim <= 8'd0;
    end else if (apply) begin
      state    <= cfg_state(pend_q);
      pat_id   <= pend_q.pat;
      hold_cnt <= 8'd0;
      hold_lim <= pend_q.hold;
    end else if (frame_start && state == ST_AUTO) begin
      if (hold_cnt == hold_last(hold_lim)) begin
        pat_id   <= pat_id + 2'd1;
        hold_cnt <= 8'd0;
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BAR_W    (BAR_W),
    .CHK_SH   (CHK_SH)
  ) u_gen (
    .hpix (HPixel),
    .vpix (VPixel),
    .pat  (pat_id),
    .en   (state != ST_IDLE),
    .r    (gen_r),
    .g    (gen_g),
    .b    (gen_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inR <= 8'd0;
      inG <= 8'd0;
      inB <= 8'd0;
    end else begin
      inR <= gen_r;
      inG <= gen_g;
      inB <= gen_b;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Directed self-checking bench for vga_pattern_sched.
// Inputs change on the falling edge; outputs are checked there too.
module tb_vga_pattern_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] HPixel;
  logic [15:0] VPixel;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_auto;
  logic [1:0]  cfg_pat;
  logic [7:0]  cfg_hold;
  logic        cfg_en;
  logic [7:0]  inR;
  logic [7:0]  inG;
  logic [7:0]  inB;
  logic [1:0]  pat_id;
  logic        frame_start;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_pattern_sched dut (
    .clk         (clk),
    .rst         (rst),
    .HPixel      (HPixel),
    .VPixel      (VPixel),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_auto    (cfg_auto),
    .cfg_pat     (cfg_pat),
    .cfg_hold    (cfg_hold),
    .cfg_en      (cfg_en),
    .inR         (inR),
    .inG         (inG),
    .inB         (inB),
    .pat_id      (pat_id),
    .frame_start (frame_start)
  );

  task automatic pix(input int h, input int v);
    @(negedge clk);
    HPixel = 16'(h);
    VPixel = 16'(v);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic frame();
    pix(5, 5);
    pix(0, 0);
    pix(5, 5);
  endtask

  task automatic send_cfg(input logic en, input logic au,
                          input logic [1:0] p, input logic [7:0] h);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_auto  = au;
    cfg_pat   = p;
    cfg_hold  = h;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_en = 1'b0;
    cfg_auto = 1'b0;
    cfg_pat = 2'd0;
    cfg_hold = 8'd0;
    HPixel = 16'd0;
    VPixel = 16'd0;
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errs++; $display("FAIL rst_ready got=%0b exp=1", cfg_ready);
    end
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL rst_rgb got=%06h exp=000000", {inR, inG, inB});
    end
    checks++;
    if (pat_id !== 2'd0 || frame_start !== 1'b0) begin
      errs++; $display("FAIL rst_pat_fs got=%0d/%0b exp=0/0", pat_id, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (frame_start !== 1'b0) begin
      errs++; $display("FAIL rst_no_stale_fs got=%0b exp=0", frame_start);
    end
  endtask

  task automatic test_fixed_bars();
    send_cfg(1'b1, 1'b0, 2'd1, 8'd0);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errs++; $display("FAIL bars_ready_low got=%0b exp=0", cfg_ready);
    end
    pix(5, 5);
    pix(0, 0);
    checks++;
    if (frame_start !== 1'b1) begin
      errs++; $display("FAIL bars_fs got=%0b exp=1", frame_start);
    end
    pix(5, 5);
    checks++;
    if (cfg_ready !== 1'b1 || pat_id !== 2'd1) begin
      errs++; $display("FAIL bars_apply got=%0b/%0d exp=1/1", cfg_ready, pat_id);
    end
    pix(85, 10);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'h0000ff) begin
      errs++; $display("FAIL bars_85 got=%06h exp=0000ff", {inR, inG, inB});
    end
    pix(700, 10);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL bars_700 got=%06h exp=000000", {inR, inG, inB});
    end
    pix(250, 10);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'h00ffff) begin
      errs++; $display("FAIL bars_250 got=%06h exp=00ffff", {inR, inG, inB});
    end
    pix(639, 10);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'hffffff) begin
      errs++; $display("FAIL bars_639 got=%06h exp=ffffff", {inR, inG, inB});
    end
    pix(100, 480);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL bars_v480 got=%06h exp=000000", {inR, inG, inB});
    end
  endtask

  task automatic test_gradient();
    send_cfg(1'b1, 1'b0, 2'd3, 8'd0);
    frame();
    pix(200, 50);
    step();
    checks++;
    if ({inR, inG, inB} !== {8'd50, 8'd25, 8'd43}) begin
      errs++; $display("FAIL grad got=%06h exp=32192b", {inR, inG, inB});
    end
  endtask

  task automatic test_auto();
    logic [1:0] seq [6] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    send_cfg(1'b1, 1'b1, 2'd2, 8'd3);
    frame();
    checks++;
    if (pat_id !== 2'd2) begin
      errs++; $display("FAIL auto_start got=%0d exp=2", pat_id);
    end
    pix(32, 0);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'hffffff) begin
      errs++; $display("FAIL chk_white got=%06h exp=ffffff", {inR, inG, inB});
    end
    pix(32, 32);
    step();
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL chk_black got=%06h exp=000000", {inR, inG, inB});
    end
    for (int i = 0; i < 6; i++) begin
      frame();
      checks++;
      if (pat_id !== seq[i]) begin
        errs++; $display("FAIL auto_seq%0d got=%0d exp=%0d", i, pat_id, seq[i]);
      end
    end
  endtask

  task automatic test_hold0();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    send_cfg(1'b1, 1'b1, 2'd1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      frame();
      checks++;
      if (pat_id !== seq[i]) begin
        errs++; $display("FAIL hold0_seq%0d got=%0d exp=%0d", i, pat_id, seq[i]);
      end
    end
  endtask

  task automatic test_midframe();
    send_cfg(1'b1, 1'b0, 2'd0, 8'd0);
    frame();
    pix(100, 100);
    send_cfg(1'b1, 1'b0, 2'd1, 8'd0);
    step();
    checks++;
    if (cfg_ready !== 1'b0 || pat_id !== 2'd0) begin
      errs++; $display("FAIL mid_hold got=%0b/%0d exp=0/0", cfg_ready, pat_id);
    end
    checks++;
    if ({inR, inG, inB} !== 24'hffffff) begin
      errs++; $display("FAIL mid_rgb got=%06h exp=ffffff", {inR, inG, inB});
    end
    pix(0, 0);
    checks++;
    if (cfg_ready !== 1'b0 || frame_start !== 1'b1) begin
      errs++; $display("FAIL mid_fs got=%0b/%0b exp=0/1", cfg_ready, frame_start);
    end
    pix(5, 5);
    checks++;
    if (cfg_ready !== 1'b1 || pat_id !== 2'd1) begin
      errs++; $display("FAIL mid_apply got=%0b/%0d exp=1/1", cfg_ready, pat_id);
    end
  endtask

  task automatic test_coincide();
    pix(5, 5);
    @(negedge clk);
    HPixel = 16'd0;
    VPixel = 16'd0;
    cfg_valid = 1'b1;
    cfg_en = 1'b1;
    cfg_auto = 1'b0;
    cfg_pat = 2'd2;
    cfg_hold = 8'd0;
    #1;
    checks++;
    if (frame_start !== 1'b1 || cfg_ready !== 1'b1) begin
      errs++; $display("FAIL co_fs got=%0b/%0b exp=1/1", frame_start, cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    HPixel = 16'd5;
    VPixel = 16'd5;
    #1;
    checks++;
    if (pat_id !== 2'd1 || cfg_ready !== 1'b0) begin
      errs++; $display("FAIL co_defer got=%0d/%0b exp=1/0", pat_id, cfg_ready);
    end
    frame();
    checks++;
    if (pat_id !== 2'd2 || cfg_ready !== 1'b1) begin
      errs++; $display("FAIL co_apply got=%0d/%0b exp=2/1", pat_id, cfg_ready);
    end
  endtask

  task automatic test_rst_pending();
    pix(100, 100);
    send_cfg(1'b1, 1'b0, 2'd3, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || pat_id !== 2'd0) begin
      errs++; $display("FAIL rp_async got=%0b/%0d exp=1/0", cfg_ready, pat_id);
    end
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL rp_rgb got=%06h exp=000000", {inR, inG, inB});
    end
    @(negedge clk);
    rst = 1'b0;
    frame();
    pix(100, 100);
    step();
    checks++;
    if (pat_id !== 2'd0 || cfg_ready !== 1'b1) begin
      errs++; $display("FAIL rp_discard got=%0d/%0b exp=0/1", pat_id, cfg_ready);
    end
    checks++;
    if ({inR, inG, inB} !== 24'h0) begin
      errs++; $display("FAIL rp_idle got=%06h exp=000000", {inR, inG, inB});
    end
  endtask

  initial begin
    test_reset();
    test_fixed_bars();
    test_gradient();
    test_auto();
    test_hold0();
    test_midframe();
    test_coincide();
    test_rst_pending();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
